// File: rtl/add_signed_serial.sv
// Digit-serial signed adder: DIGIT bits per cycle, LSB digit first, with valid/ready on both sides.
// Define ADD_SIGNED_SERIAL_SAT_EN to saturate the result on signed overflow.
module add_signed_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_digit_check
    $fatal(1, "add_signed_serial: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q, result_q;
  logic              overflow_q;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic [DIGIT:0]    dsum;
  logic              ovf_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;
  assign overflow  = overflow_q;

  always_comb begin
    dsum = {1'b0, a_q[int'(cnt)*DIGIT +: DIGIT]}
         + {1'b0, b_q[int'(cnt)*DIGIT +: DIGIT]}
         + {{DIGIT{1'b0}}, carry};
  end

  // On the last digit, dsum[DIGIT-1] is the sum's sign bit.
  assign ovf_last = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (dsum[DIGIT-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      cnt        <= '0;
      carry      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          result_q[int'(cnt)*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
          carry <= dsum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            overflow_q <= ovf_last;
`ifdef ADD_SIGNED_SERIAL_SAT_EN
            if (ovf_last)
              result_q <= a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/add_signed_serial.md
Name: add_signed_serial

Overview:
- Multi-cycle signed two's-complement adder; the additive counterpart of the team's signed subtractor.
- Accepts A and B through a valid/ready handshake.
- Adds DIGIT bits per cycle, LSB digit first, with a registered carry between digits.
- Returns result and overflow through a valid/ready handshake.
- Used where a full-width single-cycle adder is too costly in area or timing.

Parameters:
WIDTH, 32, operand/result width in bits.
DIGIT, 8, bits added per cycle; must divide WIDTH exactly (elaboration-time check, fatal on violation).

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operands A and B are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
A  input  WIDTH  signed operand, sampled on input handshake.
B  input  WIDTH  signed operand, sampled on input handshake.
out_valid  output  1  result and overflow are valid.
out_ready  input  1  downstream accepts result.
result  output  WIDTH  signed sum A+B, modulo 2^WIDTH.
overflow  output  1  signed overflow flag.
busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Registered state machine.
- Reset (async, any state, including mid-RUN):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - result=0; overflow=0; digit counter=0; carry=0; operand registers=0.
  - Any in-flight operation is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A and B, clear carry, clear counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: digit k = counter adds A[k*DIGIT +: DIGIT] + B[same] + carry.
  - Write that DIGIT-bit sum into result[k*DIGIT +: DIGIT]; register carry-out; increment counter.
  - After digit WIDTH/DIGIT-1 completes: go to DONE, out_valid=1.
  - A/B port changes during RUN are ignored.
- Latency: input handshake on edge t gives out_valid=1 after edge t+WIDTH/DIGIT (4 cycles at defaults).
- DONE:
  - out_valid=1; result and overflow held stable until out_ready is sampled high.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
  - The next operand handshake can occur one cycle later; no same-cycle overlap.
  - Result and overflow registers keep their last value after the output handshake.
- Arithmetic:
  - Final carry-out of the MSB digit is discarded, so the sum wraps modulo 2^WIDTH.
  - overflow = (A[WIDTH-1]==B[WIDTH-1]) && (sum[WIDTH-1]!=A[WIDTH-1]), using latched operands and the unsaturated sum.
  - overflow is valid whenever out_valid=1.
- in_valid while not in IDLE: ignored, no effect.
- out_ready while out_valid=0: ignored, no effect.
- busy = (state != IDLE).

Optional Feature:
Macro: ADD_SIGNED_SERIAL_SAT_EN.
- Defined:
  - When overflow=1, result is replaced at RUN->DONE by the saturated value.
  - Positive overflow (A[WIDTH-1]=0) saturates to 2^(WIDTH-1)-1, i.e. 0x7FFFFFFF.
  - Negative overflow saturates to -2^(WIDTH-1), i.e. 0x80000000.
  - overflow flag still asserts as defined above.
  - Latency is unchanged.
- Undefined: result wraps modulo 2^WIDTH; no saturation logic is synthesised.

Test Plan:
1. Basic add, defaults: A=5, B=7 handshake at cycle 0 -> out_valid at cycle 4, result=12, overflow=0; in_ready=0 and busy=1 during cycles 1-4.
2. Carry across digits and wrap: A=0x000000FF, B=1 -> 0x00000100, overflow=0. A=-3 (0xFFFFFFFD), B=3 -> 0x00000000, overflow=0 (carry-out discarded).
3. Positive overflow: A=0x7FFFFFFF, B=1 -> overflow=1; result=0x80000000 without the macro, 0x7FFFFFFF with ADD_SIGNED_SERIAL_SAT_EN.
4. Negative overflow: A=0x80000000, B=0xFFFFFFFF -> overflow=1; result=0x7FFFFFFF without the macro, 0x80000000 with it.
5. Backpressure: out_ready held low for 5 cycles after out_valid, with in_valid=1 and new A/B driven throughout -> result held stable, in_ready=0, new operands not taken. out_ready=1 for one cycle -> out_valid=0 next cycle and in_ready=1. Next handshake computes from the newly presented operands.
6. Reset mid-operation: assert rst asynchronously 2 cycles into RUN -> out_valid=0, in_ready=1, result=0, overflow=0 immediately. After release, A=-100, B=40 -> result=-60 (0xFFFFFFC4), overflow=0, 4 cycles after accept.
